// File: rtl/qmax_reader_if.sv
// Request/result handshake plus Q-table RAM read and snooped write port for qmax_reader.
// Epsilon-greedy signals exist only when QMAX_EPSILON_EN is defined.
interface qmax_reader_if #(
  parameter int unsigned ACT_W   = 2,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned Q_W     = 16
);
  logic                     start;
  logic [STATE_W-1:0]       state_in;
  logic                     busy;
  logic                     done;
  logic [Q_W-1:0]           max_q;
  logic [ACT_W-1:0]         best_action;
  logic                     mem_rd_en;
  logic [STATE_W+ACT_W-1:0] mem_rd_addr;
  logic [Q_W-1:0]           mem_rd_data;
  logic                     wr_en;
  logic [STATE_W+ACT_W-1:0] wr_addr;
  logic [Q_W-1:0]           wr_data;
`ifdef QMAX_EPSILON_EN
  logic [7:0]               epsilon;
  logic                     explore;

  modport master (
    output start, state_in, mem_rd_data, wr_en, wr_addr, wr_data, epsilon,
    input  busy, done, max_q, best_action, mem_rd_en, mem_rd_addr, explore
  );
  modport slave (
    input  start, state_in, mem_rd_data, wr_en, wr_addr, wr_data, epsilon,
    output busy, done, max_q, best_action, mem_rd_en, mem_rd_addr, explore
  );
`else
  modport master (
    output start, state_in, mem_rd_data, wr_en, wr_addr, wr_data,
    input  busy, done, max_q, best_action, mem_rd_en, mem_rd_addr
  );
  modport slave (
    input  start, state_in, mem_rd_data, wr_en, wr_addr, wr_data,
    output busy, done, max_q, best_action, mem_rd_en, mem_rd_addr
  );
`endif
endinterface

// File: rtl/qmax_reader.sv
// Sweeps all action entries of one state in the Q-table and returns the signed max and its index.
// Define QMAX_EPSILON_EN for epsilon-greedy action selection driven by a 16-bit LFSR.
module qmax_reader #(
  parameter int unsigned N_ACTIONS = 4,
  parameter int unsigned ACT_W     = 2,
  parameter int unsigned STATE_W   = 4,
  parameter int unsigned Q_W       = 16
) (
  input logic          clk,
  input logic          rst_n,
  qmax_reader_if.slave bus
);
  localparam int unsigned       ADDR_W   = STATE_W + ACT_W;
  localparam logic [ACT_W-1:0]  LAST_ACT = ACT_W'(N_ACTIONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [STATE_W-1:0]  st_q;
  logic [ACT_W-1:0]    act_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [Q_W-1:0]      max_q_q;
  logic [ACT_W-1:0]    best_q;

  // Return-side pipeline: what was issued last cycle and whether a write hit it then.
  logic                ret_vld_q;
  logic [ACT_W-1:0]    ret_act_q;
  logic                iss_hit_q;
  logic [Q_W-1:0]      iss_data_q;
  logic [Q_W-1:0]      run_max_q;
  logic [ACT_W-1:0]    run_act_q;

  logic [ADDR_W-1:0]   ret_addr;
  logic [Q_W-1:0]      word_d;
  logic [Q_W-1:0]      run_max_d;
  logic [ACT_W-1:0]    run_act_d;
  logic                take;

`ifdef QMAX_EPSILON_EN
  logic [15:0]         lfsr_q;
  logic                explore_q;
`endif

  // A write in the return cycle is newer than one seen at issue, so it takes priority.
  always_comb begin
    ret_addr = {st_q, ret_act_q};
    if (bus.wr_en && (bus.wr_addr == ret_addr)) begin
      word_d = bus.wr_data;
    end else if (iss_hit_q) begin
      word_d = iss_data_q;
    end else begin
      word_d = bus.mem_rd_data;
    end
    take      = ret_vld_q && ((ret_act_q == '0) || ($signed(word_d) > $signed(run_max_q)));
    run_max_d = take ? word_d : run_max_q;
    run_act_d = take ? ret_act_q : run_act_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      st_q       <= '0;
      act_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      max_q_q    <= '0;
      best_q     <= '0;
      ret_vld_q  <= 1'b0;
      ret_act_q  <= '0;
      iss_hit_q  <= 1'b0;
      iss_data_q <= '0;
      run_max_q  <= '0;
      run_act_q  <= '0;
`ifdef QMAX_EPSILON_EN
      lfsr_q     <= 16'hACE1;
      explore_q  <= 1'b0;
`endif
    end else begin
      ret_vld_q  <= rd_en_q;
      ret_act_q  <= rd_addr_q[ACT_W-1:0];
      iss_hit_q  <= rd_en_q && bus.wr_en && (bus.wr_addr == rd_addr_q);
      iss_data_q <= bus.wr_data;
      run_max_q  <= run_max_d;
      run_act_q  <= run_act_d;
`ifdef QMAX_EPSILON_EN
      lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= ISSUE;
            st_q      <= bus.state_in;
            act_q     <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= {bus.state_in, {ACT_W{1'b0}}};
          end
        end
        ISSUE: begin
          if (act_q == LAST_ACT) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            act_q     <= act_q + ACT_W'(1);
            rd_addr_q <= {st_q, act_q + ACT_W'(1)};
          end
        end
        DRAIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          max_q_q <= run_max_d;
`ifdef QMAX_EPSILON_EN
          if (lfsr_q[7:0] < bus.epsilon) begin
            best_q    <= lfsr_q[8 +: ACT_W];
            explore_q <= 1'b1;
          end else begin
            best_q    <= run_act_d;
            explore_q <= 1'b0;
          end
`else
          best_q  <= run_act_d;
`endif
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.max_q       = max_q_q;
  assign bus.best_action = best_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
`ifdef QMAX_EPSILON_EN
  assign bus.explore     = explore_q;
`endif

endmodule

// File: tb/tb_qmax_reader.sv
// Self-checking bench for qmax_reader: vector table of Q rows with expected max/action,
// scoreboard queue of results, plus reset-abort and (with QMAX_EPSILON_EN) exploration sequences.
`timescale 1ns/1ps
module tb_qmax_reader;
  localparam int unsigned N       = 4;
  localparam int unsigned ACT_W   = 2;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned Q_W     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned last_done = 0;
  logic [Q_W-1:0] ram [64];

  typedef struct {
    logic [STATE_W-1:0]      st;
    logic [N-1:0][Q_W-1:0]   row;
    bit                      iss;
    bit                      ret;
    int unsigned             fact;
    logic [Q_W-1:0]          d_iss;
    logic [Q_W-1:0]          d_ret;
    logic [Q_W-1:0]          exp_q;
    logic [ACT_W-1:0]        exp_a;
  } vec_t;

  typedef struct {
    logic [Q_W-1:0]   q;
    logic [ACT_W-1:0] a;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  qmax_reader_if #(.ACT_W(ACT_W), .STATE_W(STATE_W), .Q_W(Q_W)) bus ();

  qmax_reader #(.N_ACTIONS(N), .ACT_W(ACT_W), .STATE_W(STATE_W), .Q_W(Q_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, read-during-write returns old data.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
    if (bus.wr_en) ram[bus.wr_addr] = bus.wr_data;
  end

`ifdef QMAX_EPSILON_EN
  logic [15:0] ref_lfsr;
  logic [15:0] ref_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lfsr <= 16'hACE1;
      ref_prev <= 16'hACE1;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [STATE_W-1:0] st,
                              input logic [Q_W-1:0] a0, a1, a2, a3,
                              input bit iss, ret, input int unsigned fact,
                              input logic [Q_W-1:0] d_iss, d_ret, eq,
                              input logic [ACT_W-1:0] ea);
    vec_t v;
    v.st = st;
    v.row[0] = a0; v.row[1] = a1; v.row[2] = a2; v.row[3] = a3;
    v.iss = iss; v.ret = ret; v.fact = fact;
    v.d_iss = d_iss; v.d_ret = d_ret;
    v.exp_q = eq; v.exp_a = ea;
    return v;
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_rd_en"}, bus.mem_rd_en, 0);
    chk({nm, "_rd_addr"}, bus.mem_rd_addr, 0);
    chk({nm, "_max_q"}, bus.max_q, 0);
    chk({nm, "_best"}, bus.best_action, 0);
`ifdef QMAX_EPSILON_EN
    chk({nm, "_explore"}, bus.explore, 0);
`endif
  endtask

  task automatic run_sweep(input vec_t v, input bit glitch);
    int unsigned lat;
    int unsigned k;
    bit          got_done;
    exp_t        e;
    logic [ACT_W-1:0] ea;
`ifdef QMAX_EPSILON_EN
    logic        ex_explore;
`endif
    e = '{q: '0, a: '0};
    for (int i = 0; i < int'(N); i++) ram[{v.st, ACT_W'(i)}] = v.row[i];
    sbq.push_back('{q: v.exp_q, a: v.exp_a});
    bus.start = 1'b1;
    bus.state_in = v.st;
    tick();
    bus.start = 1'b0;
    bus.state_in = ~v.st;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      k = lat - 1;
      bus.wr_en = 1'b0;
      bus.start = glitch && (k == 1);
      if (v.iss && k == v.fact) begin
        bus.wr_en = 1'b1; bus.wr_addr = {v.st, ACT_W'(v.fact)}; bus.wr_data = v.d_iss;
      end
      if (v.ret && k == v.fact + 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = {v.st, ACT_W'(v.fact)}; bus.wr_data = v.d_ret;
      end
      if (k < N) begin
        chk("rd_en", bus.mem_rd_en, 1);
        chk("rd_addr", bus.mem_rd_addr, {v.st, ACT_W'(k)});
      end else begin
        chk("rd_hold", {bus.mem_rd_en, bus.mem_rd_addr}, {1'b0, v.st, ACT_W'(N - 1)});
      end
      chk("busy", bus.busy, 1);
      tick();
      lat++;
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    chk("latency", lat, N + 2);
    chk("done", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    got_done = (bus.done === 1'b1) && (sbq.size() > 0);
    if (got_done) begin
      e  = sbq.pop_front();
      ea = e.a;
`ifdef QMAX_EPSILON_EN
      ex_explore = ref_prev[7:0] < bus.epsilon;
      if (ex_explore) ea = ref_prev[8 +: ACT_W];
      chk("explore", bus.explore, ex_explore);
`endif
      chk("max_q", bus.max_q, e.q);
      chk("best_action", bus.best_action, ea);
      last_done = cyc;
    end
    tick();
    chk("done_pulse", bus.done, 0);
    chk("idle_after", bus.busy, 0);
    if (got_done) chk("max_q_hold", bus.max_q, e.q);
  endtask

  initial begin
    int unsigned prev;
    bit          seen;
    vecs[0] = mk(4'd3,  16'h0200, 16'h0700, 16'hFF00, 16'h0480, 0, 0, 0, '0, '0, 16'h0700, 2'd1);
    vecs[1] = mk(4'd5,  16'hFE00, 16'hFF80, 16'hF000, 16'hFF80, 0, 0, 0, '0, '0, 16'hFF80, 2'd1);
    vecs[2] = mk(4'd7,  16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 0, 2, 16'h0900, '0, 16'h0900, 2'd2);
    vecs[3] = mk(4'd7,  16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1, 2, '0, 16'h0900, 16'h0900, 2'd2);
    vecs[4] = mk(4'd0,  16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0, '0, '0, 16'h8000, 2'd0);
    vecs[5] = mk(4'd15, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 0, 0, 0, '0, '0, 16'h7FFF, 2'd0);
    vecs[6] = mk(4'd9,  16'h0001, 16'h0002, 16'h0003, 16'h7FFF, 0, 0, 0, '0, '0, 16'h7FFF, 2'd3);
    vecs[7] = mk(4'd2,  16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 1, 0, '0, 16'hFF00, 16'h0100, 2'd1);
    vecs[8] = mk(4'd4,  16'h0100, 16'h0100, 16'h0100, 16'h0100, 1, 1, 3, 16'h0500, 16'h0600, 16'h0600, 2'd3);

    bus.start = 1'b0; bus.state_in = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef QMAX_EPSILON_EN
    bus.epsilon = 8'd0;
`endif
    for (int i = 0; i < 64; i++) ram[i] = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      prev = last_done;
      run_sweep(vecs[i], i == 4);
      if (i > 0) chk("b2b_period", last_done - prev, N + 3);
    end

    // Start again at t+2 while busy, then reset mid-sweep at t+3.
    tick();
    bus.start = 1'b1; bus.state_in = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.done | bus.busy;
    end
    chk("no_activity_after_abort", seen, 0);
    run_sweep(vecs[0], 0);

`ifdef QMAX_EPSILON_EN
    for (int i = 0; i < 100; i++) run_sweep(vecs[i % 9], 0);
    bus.epsilon = 8'hFF;
    for (int i = 0; i < 40; i++) run_sweep(vecs[i % 9], 0);
`endif

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
